store_buffer: RTL and testbench



---
 rtl/store_buf_pkg.sv | 13 +
 rtl/store_buf_fwd.sv | 19 +
 rtl/store_buffer.sv | 85 ++++++++
 tb/tb_store_buffer.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// store_buf_pkg: shared entry type, word-align mask and pointer width helper for the store buffer
package store_buf_pkg;
  localparam int SB_ADDR_W = 32;
  localparam logic [SB_ADDR_W-1:0] SB_WORD_ALIGN = ~SB_ADDR_W'(3);
  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [31:0]          data;
    logic [3:0]           strb;
  } sb_entry_t;
  function automatic int sbPtrW(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/store_buf_fwd.sv
// store_buf_fwd: byte-lane overlay of buffered stores onto memory read data, entries ordered oldest to youngest
module store_buf_fwd import store_buf_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  sb_entry_t         entries [DEPTH],
  input  logic [DEPTH-1:0]  valid,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       memRdata,
  output logic [31:0]       rdata
);
  always_comb begin
    rdata = memRdata;
    for (int i = 0; i < DEPTH; i++)
      for (int b = 0; b < 4; b++)
        if (valid[i] && entries[i].addr == addr && entries[i].strb[b])
          rdata[8*b+:8] = entries[i].data[8*b+:8];
  end
endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between core and data memory with store-to-load forwarding.
// Optional STORE_BUF_COALESCE_EN merges a store into the youngest non-head entry of the same word.
module store_buffer import store_buf_pkg::*; #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [3:0]        MemWrite_in,
  input  logic              MemRead_in,
  input  logic [ADDR_W-1:0] Addr_in,
  input  logic [31:0]       WriteData_in,
  output logic [31:0]       ReadData_out,
  output logic              StallReq,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb
);
  localparam int PW = sbPtrW(DEPTH);
  sb_entry_t mem [DEPTH];
  sb_entry_t ordered [DEPTH];
  logic [DEPTH-1:0] orderedValid;
  logic [PW-1:0] rdPtr, wrPtr, youngest;
  logic [PW:0] count;
  logic storeReq, full, push, pop, coalesce, unusedRead;
  logic [ADDR_W-1:0] wordAddr;
  assign unusedRead = MemRead_in;
  assign storeReq = |MemWrite_in;
  assign full = count == (PW+1)'(DEPTH);
  assign wordAddr = Addr_in & SB_WORD_ALIGN;
  assign youngest = wrPtr - PW'(1);
`ifdef STORE_BUF_COALESCE_EN
  // the head may be mid-handshake, so only a non-head youngest entry (count>=2) absorbs stores
  assign coalesce = storeReq && count >= (PW+1)'(2) && mem[youngest].addr == wordAddr;
`else
  assign coalesce = 1'b0;
`endif
  assign StallReq = storeReq && full && !mem_wready && !coalesce;
  assign push = storeReq && !StallReq && !coalesce;
  assign pop = mem_wvalid && mem_wready;
  assign mem_wvalid = count != '0;
  assign mem_waddr = mem[rdPtr].addr;
  assign mem_wdata = mem[rdPtr].data;
  assign mem_wstrb = mem[rdPtr].strb;
  assign mem_raddr = wordAddr;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= '{addr: wordAddr, data: WriteData_in, strb: MemWrite_in};
        wrPtr <= wrPtr + PW'(1);
      end
`ifdef STORE_BUF_COALESCE_EN
      if (coalesce) begin
        for (int b = 0; b < 4; b++)
          if (MemWrite_in[b]) mem[youngest].data[8*b+:8] <= WriteData_in[8*b+:8];
        mem[youngest].strb <= mem[youngest].strb | MemWrite_in;
      end
`endif
      if (pop) rdPtr <= rdPtr + PW'(1);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end
  // present entries oldest-first so the overlay's last match is the youngest
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ordered[i] = mem[rdPtr + PW'(i)];
      orderedValid[i] = (PW+1)'(i) < count;
    end
  end
  store_buf_fwd #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) fwd (
    .entries  (ordered),
    .valid    (orderedValid),
    .addr     (wordAddr),
    .memRdata (mem_rdata),
    .rdata    (ReadData_out)
  );
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench; stimulus queues expected drains/loads, a negedge monitor checks them
module tb_store_buffer;
  import store_buf_pkg::*;
  logic CLK = 1'b0, RESET, MemRead_in, StallReq, mem_wvalid, mem_wready;
  logic [3:0] MemWrite_in, mem_wstrb;
  logic [31:0] Addr_in, WriteData_in, ReadData_out, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  int errors = 0, checks = 0;
  sb_entry_t drainQ[$];
  logic [31:0] loadQ[$];
  always #5 CLK = ~CLK;
  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .CLK(CLK), .RESET(RESET), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .Addr_in(Addr_in), .WriteData_in(WriteData_in), .ReadData_out(ReadData_out),
    .StallReq(StallReq), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge CLK) begin
    sb_entry_t e;
    if (!RESET) begin
      if (mem_wvalid && mem_wready) begin
        if (drainQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_drain: got addr %h, none expected", mem_waddr);
        end else begin
          e = drainQ.pop_front();
          chk("drain_addr", mem_waddr, e.addr);
          chk("drain_data", mem_wdata, e.data);
          chk("drain_strb", {28'h0, mem_wstrb}, {28'h0, e.strb});
        end
      end
      if (MemRead_in && MemWrite_in == 4'h0) begin
        if (loadQ.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_load: got %h, none expected", ReadData_out);
        end else chk("load_data", ReadData_out, loadQ.pop_front());
      end
    end
  end
  task automatic tick();
    @(posedge CLK); #1;
  endtask
  task automatic idle();
    MemWrite_in = 4'h0; MemRead_in = 1'b0;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    MemWrite_in = s; MemRead_in = 1'b0; Addr_in = a; WriteData_in = d;
    drainQ.push_back('{addr: {a[31:2], 2'b00}, data: d, strb: s});
    tick(); idle();
  endtask
  task automatic load(input logic [31:0] a, input logic [31:0] r, input logic [31:0] exp);
    MemRead_in = 1'b1; MemWrite_in = 4'h0; Addr_in = a; mem_rdata = r;
    loadQ.push_back(exp);
    @(negedge CLK);
    chk("raddr", mem_raddr, {a[31:2], 2'b00});
    tick(); idle();
  endtask
  task automatic drain();
    int n = 0;
    mem_wready = 1'b1;
    @(negedge CLK);
    while (mem_wvalid && n < 20) begin @(negedge CLK); n++; end
    chk("drain_done", {31'h0, mem_wvalid}, 32'h0);
    chk("drain_left", drainQ.size(), 32'h0);
    tick(); mem_wready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "timeout");
  end
  initial begin
    RESET = 1'b1; idle(); Addr_in = '0; WriteData_in = '0; mem_rdata = '0; mem_wready = 1'b0;
    tick(); tick(); RESET = 1'b0;
    @(negedge CLK);
    chk("rst_wvalid", {31'h0, mem_wvalid}, 32'h0);
    chk("rst_stall", {31'h0, StallReq}, 32'h0);
    chk("rst_count", dut.count, 32'h0);
    tick();
    load(32'h100, 32'hCAFED00D, 32'hCAFED00D);
    // store drains the cycle after acceptance
    mem_wready = 1'b1;
    store(32'h1000, 32'hDEADBEEF, 4'hF);
    @(negedge CLK);
    chk("t1_wvalid", {31'h0, mem_wvalid}, 32'h1);
    tick();
    @(negedge CLK);
    chk("t1_count", dut.count, 32'h0);
    chk("t1_wvalid_after", {31'h0, mem_wvalid}, 32'h0);
    tick(); mem_wready = 1'b0;
    store(32'h2001, 32'h0000AA00, 4'b0010);
    load(32'h2000, 32'h11223344, 32'h1122AA44);
    drain();
    for (int i = 0; i < 4; i++) store(32'h6000 + 32'(4*i), 32'h11111111 * 32'(i+1), 4'hF);
    MemWrite_in = 4'hF; Addr_in = 32'h7000; WriteData_in = 32'h77777777;
    @(negedge CLK);
    chk("full_stall", {31'h0, StallReq}, 32'h1);
    tick();
    @(negedge CLK);
    chk("full_stall_hold", {31'h0, StallReq}, 32'h1);
    chk("full_count", dut.count, 32'h4);
    tick();
    mem_wready = 1'b1;
    drainQ.push_back('{addr: 32'h7000, data: 32'h77777777, strb: 4'hF});
    @(negedge CLK);
    chk("full_ready_stall", {31'h0, StallReq}, 32'h0);
    tick(); idle();
    @(negedge CLK);
    chk("full_swap_count", dut.count, 32'h4);
    tick(); mem_wready = 1'b0;
    drain();
    store(32'h3000, 32'h00000001, 4'h1);
    store(32'h3000, 32'h00000002, 4'h1);
    load(32'h3000, 32'hFFFFFFFF, 32'hFFFFFF02);
    drain();
    store(32'h3104, 32'hAABBCCDD, 4'b1001);
    store(32'h3108, 32'h99999999, 4'hF);
    store(32'h3104, 32'h00EE0000, 4'b0100);
    load(32'h3106, 32'h12345678, 32'hAAEE56DD);
    drain();
    for (int i = 0; i < 3; i++) store(32'h6000, 32'hA0A0A0A0 + 32'(i), 4'hF);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    drainQ.delete();
    @(negedge CLK);
    chk("rst2_wvalid", {31'h0, mem_wvalid}, 32'h0);
    chk("rst2_count", dut.count, 32'h0);
    tick();
    load(32'h6000, 32'h55667788, 32'h55667788);
`ifdef STORE_BUF_COALESCE_EN
    store(32'h5000, 32'h12345678, 4'hF);
    drainQ.push_back('{addr: 32'h4000, data: 32'hCAFEBEEF, strb: 4'hF});
    MemWrite_in = 4'b0011; Addr_in = 32'h4000; WriteData_in = 32'h0000BEEF;
    tick();
    MemWrite_in = 4'b1100; Addr_in = 32'h4002; WriteData_in = 32'hCAFE0000;
    tick(); idle();
    @(negedge CLK);
    chk("coal_count", dut.count, 32'h2);
    tick();
    load(32'h4000, 32'h0, 32'hCAFEBEEF);
    drain();
`endif
    chk("load_left", loadQ.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
